// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus scheduler.
package rtc_bus_pkg;

  localparam int DATA_W = 8;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 10;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_REC_DEF   = 4;

  localparam logic CS_IDLE  = 1'b1;
  localparam logic RD_IDLE  = 1'b1;
  localparam logic WR_IDLE  = 1'b1;
  localparam logic AOD_IDLE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_SET,
    S_A_STB,
    S_A_HLD,
    S_D_SET,
    S_D_STB,
    S_D_HLD,
    S_REC
  } state_e;

  typedef struct packed {
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              aod;
    logic              oe;
    logic [DATA_W-1:0] bout;
  } pins_t;

  function automatic int tmax(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// Requester handshake plus RTC pin bundle; slave is the scheduler side.
interface rtc_bus_scheduler_if
  import rtc_bus_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [DATA_W*NREQ-1:0] req_addr;
  logic [DATA_W*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;

  logic                   ChipSelect;
  logic                   Read;
  logic                   Write;
  logic                   AoD;
  logic [DATA_W-1:0]      bus_out;
  logic                   bus_oe;
  logic [DATA_W-1:0]      bus_in;

  modport master (
    output req, req_we, req_addr, req_wdata, bus_in,
    input  gnt, done, rdata, busy, ChipSelect, Read, Write, AoD, bus_out, bus_oe
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, bus_in,
    output gnt, done, rdata, busy, ChipSelect, Read, Write, AoD, bus_out, bus_oe
  );

endinterface

// File: rtl/rtc_bus_scheduler_timer.sv
// Loadable down-counter that parks at zero; sets the length of each bus phase.
module rtc_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Fixed-priority arbiter and phase sequencer driving the RTC multiplexed address/data bus.
module rtc_bus_scheduler
  import rtc_bus_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_REC   = T_REC_DEF
) (
  input  logic                clk,
  input  logic                Reset,
  rtc_bus_scheduler_if.slave  bus
);

  localparam int TW = $clog2(tmax(T_SETUP, T_PULSE, T_HOLD, T_REC) + 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d, pick;
  logic              we_q, we_d, we_sel;
  logic [DATA_W-1:0] addr_q, addr_d, addr_sel;
  logic [DATA_W-1:0] wdata_q, wdata_d, wdata_sel;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  pins_t             pins_q, pins_d;
  logic              tmr_zero, tmr_load, arb_en;
  logic [TW-1:0]     tmr_val;

  function automatic logic [TW-1:0] phase_len(state_e s);
    case (s)
      S_A_SET, S_D_SET: return TW'(T_SETUP - 1);
      S_A_STB, S_D_STB: return TW'(T_PULSE - 1);
      S_A_HLD, S_D_HLD: return TW'(T_HOLD - 1);
      S_REC:            return TW'(T_REC - 1);
      default:          return '0;
    endcase
  endfunction

  // Pin levels are a pure function of the phase, so they are registered from
  // the next state to give glitch-free strobes with no added latency.
  function automatic pins_t decode(state_e s, logic we, logic [DATA_W-1:0] a,
                                   logic [DATA_W-1:0] d);
    pins_t p;
    p.cs_n = CS_IDLE;
    p.rd_n = RD_IDLE;
    p.wr_n = WR_IDLE;
    p.aod  = AOD_IDLE;
    p.oe   = 1'b0;
    p.bout = '0;
    case (s)
      S_A_SET, S_A_STB, S_A_HLD: begin
        p.cs_n = 1'b0;
        p.aod  = 1'b0;
        p.oe   = 1'b1;
        p.bout = a;
        if (s == S_A_STB) p.wr_n = 1'b0;
      end
      S_D_SET, S_D_STB, S_D_HLD: begin
        p.cs_n = 1'b0;
        if (we) begin
          p.oe   = 1'b1;
          p.bout = d;
          if (s == S_D_STB) p.wr_n = 1'b0;
        end else if (s == S_D_STB) begin
          p.rd_n = 1'b0;
        end
      end
      default: ;
    endcase
    return p;
  endfunction

  rtc_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Lowest set bit wins: index 0 has top priority.
  always_comb begin
    pick      = bus.req & (~bus.req + NREQ'(1));
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        we_sel    = bus.req_we[i];
        addr_sel  = bus.req_addr[i*DATA_W +: DATA_W];
        wdata_sel = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_A_SET: if (tmr_zero) state_d = S_A_STB;
      S_A_STB: if (tmr_zero) state_d = S_A_HLD;
      S_A_HLD: if (tmr_zero) state_d = S_D_SET;
      S_D_SET: if (tmr_zero) state_d = S_D_STB;
      S_D_STB: if (tmr_zero) begin
        state_d = S_D_HLD;
        if (!we_q) rdata_d = bus.bus_in;
      end
      S_D_HLD: if (tmr_zero) state_d = S_REC;
      S_REC: if (tmr_zero) begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: ;
    endcase

    // A request pending at the end of recovery starts straight away, keeping
    // back-to-back spacing at exactly T_REC cycles of ChipSelect high.
    arb_en = (state_q == S_IDLE) || ((state_q == S_REC) && tmr_zero);
    if (arb_en && (|bus.req)) begin
      state_d = S_A_SET;
      gnt_d   = pick;
      we_d    = we_sel;
      addr_d  = addr_sel;
      wdata_d = wdata_sel;
    end

    done_d   = ((state_d == S_REC) && (state_q != S_REC)) ? gnt_q : '0;
    tmr_load = (state_d != state_q);
    tmr_val  = phase_len(state_d);
    pins_d   = decode(state_d, we_d, addr_d, wdata_d);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      pins_q  <= '{cs_n: CS_IDLE, rd_n: RD_IDLE, wr_n: WR_IDLE, aod: AOD_IDLE,
                   oe: 1'b0, bout: '0};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      pins_q  <= pins_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.ChipSelect = pins_q.cs_n;
  assign bus.Read       = pins_q.rd_n;
  assign bus.Write      = pins_q.wr_n;
  assign bus.AoD        = pins_q.aod;
  assign bus.bus_oe     = pins_q.oe;
  assign bus.bus_out    = pins_q.bout;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed scoreboard bench for rtc_bus_scheduler with a pin-level monitor.
module tb_rtc_bus_scheduler;

  typedef struct {
    int         idx;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         gap;
  } exp_t;

  logic       clk;
  logic       Reset;
  logic [7:0] rd_val;
  int         checks;
  int         errors;
  exp_t       sb[$];

  rtc_bus_scheduler_if #(.NREQ(4)) ifc ();

  rtc_bus_scheduler #(.NREQ(4)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (ifc)
  );

  // RTC model: presents rd_val only while the read strobe is low.
  assign ifc.bus_in = (ifc.Read == 1'b0) ? rd_val : 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: accumulates per-transaction pin activity and compares on done.
  int   cyc, last_done, cs_cnt, wa_cnt, wd_cnt, rd_cnt, wr_falls, cur_gap;
  logic [7:0] a_seen, d_seen;
  bit   addr_oe_bad, d_oe_seen, prev_cs, prev_wr;
  exp_t e;

  task automatic clear_mon();
    cs_cnt = 0; wa_cnt = 0; wd_cnt = 0; rd_cnt = 0; wr_falls = 0; cur_gap = -1;
    a_seen = 8'h00; d_seen = 8'h00; addr_oe_bad = 1'b0; d_oe_seen = 1'b0;
  endtask

  initial begin
    cyc = 0; last_done = -1000; prev_cs = 1'b1; prev_wr = 1'b1;
    clear_mon();
    forever begin
      @(negedge clk);
      cyc++;
      if (!Reset) begin
        clear_mon();
        prev_cs = 1'b1;
        prev_wr = 1'b1;
      end else begin
        chk("rd_wr_not_both_low", {31'd0, ifc.Read | ifc.Write}, 1);
        if (!ifc.busy) chk("cs_high_when_idle", {31'd0, ifc.ChipSelect}, 1);
        if (!ifc.Read) chk("oe_off_while_read", {31'd0, ifc.bus_oe}, 0);
        if (!ifc.ChipSelect) begin
          if (prev_cs) cur_gap = cyc - last_done;
          cs_cnt++;
          if (!ifc.AoD) begin
            if (!ifc.bus_oe) addr_oe_bad = 1'b1;
            if (!ifc.Write) begin wa_cnt++; a_seen = ifc.bus_out; end
          end else begin
            if (ifc.bus_oe) d_oe_seen = 1'b1;
            if (!ifc.Write) begin wd_cnt++; d_seen = ifc.bus_out; end
            if (!ifc.Read) rd_cnt++;
          end
          if (!ifc.Write && prev_wr) wr_falls++;
        end
        prev_cs = ifc.ChipSelect;
        prev_wr = ifc.Write;
        if (ifc.done != 4'b0000) begin
          last_done = cyc;
          chk("done_expected", {31'd0, sb.size() != 0}, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_onehot", {28'd0, ifc.done}, 32'd1 << e.idx);
            chk("gnt_at_done", {28'd0, ifc.gnt}, 32'd1 << e.idx);
            chk("cs_low_cycles", cs_cnt, 28);
            chk("addr_wr_pulse", wa_cnt, 10);
            chk("addr_on_bus", {24'd0, a_seen}, {24'd0, e.addr});
            chk("addr_phase_oe", {31'd0, addr_oe_bad}, 0);
            if (e.we) begin
              chk("data_wr_pulse", wd_cnt, 10);
              chk("data_on_bus", {24'd0, d_seen}, {24'd0, e.wdata});
              chk("write_pulses", wr_falls, 2);
              chk("no_read_on_write", rd_cnt, 0);
            end else begin
              chk("read_pulse", rd_cnt, 10);
              chk("no_data_write", wd_cnt, 0);
              chk("write_pulses", wr_falls, 1);
              chk("data_oe_off", {31'd0, d_oe_seen}, 0);
              chk("rdata", {24'd0, ifc.rdata}, {24'd0, e.rdata});
            end
            if (e.gap >= 0) chk("start_gap", cur_gap, e.gap);
          end
          clear_mon();
        end
      end
    end
  end

  task automatic do_req(input int idx, input bit we, input logic [7:0] a,
                        input logic [7:0] d, input int n);
    int got;
    int waitc;
    got = 0;
    ifc.req_we[idx]           = we;
    ifc.req_addr[idx*8 +: 8]  = a;
    ifc.req_wdata[idx*8 +: 8] = d;
    ifc.req[idx]              = 1'b1;
    while (got < n) begin
      waitc = 0;
      do begin
        @(negedge clk);
        waitc++;
      end while (!ifc.done[idx] && waitc < 200);
      chk($sformatf("done%0d_seen", idx), {31'd0, ifc.done[idx]}, 1);
      if (!ifc.done[idx]) break;
      got++;
    end
    ifc.req[idx] = 1'b0;
  endtask

  function automatic exp_t mk(int idx, bit we, logic [7:0] a, logic [7:0] d,
                              logic [7:0] r, int gap);
    exp_t x;
    x.idx = idx; x.we = we; x.addr = a; x.wdata = d; x.rdata = r; x.gap = gap;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    checks = 0; errors = 0;
    rd_val = 8'h00;
    ifc.req = '0; ifc.req_we = '0; ifc.req_addr = '0; ifc.req_wdata = '0;
    Reset = 1'b1;
    #2 Reset = 1'b0;
    #1;
    chk("reset_pins", {26'd0, ifc.ChipSelect, ifc.Read, ifc.Write, ifc.AoD, ifc.bus_oe, ifc.busy},
        6'b111100);
    chk("reset_bus_out", {24'd0, ifc.bus_out}, 0);
    chk("reset_gnt_done", {24'd0, ifc.gnt, ifc.done}, 0);
    chk("reset_rdata", {24'd0, ifc.rdata}, 0);
    repeat (2) @(negedge clk);
    #2 Reset = 1'b1;
    @(negedge clk);

    // Single write from requester 1.
    sb.push_back(mk(1, 1'b1, 8'h21, 8'h45, 8'h00, -1));
    do_req(1, 1'b1, 8'h21, 8'h45, 1);
    repeat (6) @(negedge clk);

    // Single read from requester 3.
    rd_val = 8'h37;
    sb.push_back(mk(3, 1'b0, 8'h22, 8'h00, 8'h37, -1));
    do_req(3, 1'b0, 8'h22, 8'h00, 1);
    repeat (6) @(negedge clk);

    // Requesters 0 and 2 together: 0 first, 2 exactly T_REC after done[0].
    sb.push_back(mk(0, 1'b1, 8'h10, 8'h5A, 8'h00, -1));
    sb.push_back(mk(2, 1'b1, 8'h11, 8'h6B, 8'h00, 4));
    fork
      do_req(0, 1'b1, 8'h10, 8'h5A, 1);
      do_req(2, 1'b1, 8'h11, 8'h6B, 1);
    join
    chk("rdata_hold", {24'd0, ifc.rdata}, 32'h37);
    repeat (6) @(negedge clk);

    // Requester 1 held through done: identical back-to-back transaction.
    sb.push_back(mk(1, 1'b1, 8'h40, 8'h99, 8'h00, -1));
    sb.push_back(mk(1, 1'b1, 8'h40, 8'h99, 8'h00, 4));
    do_req(1, 1'b1, 8'h40, 8'h99, 2);
    repeat (6) @(negedge clk);

    // Reset during the data strobe of a write: no done for the aborted request.
    ifc.req_we[1] = 1'b1; ifc.req_addr[15:8] = 8'h55; ifc.req_wdata[15:8] = 8'hAA;
    ifc.req[1] = 1'b1;
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!(ifc.Write == 1'b0 && ifc.AoD == 1'b1) && waitc < 100);
    chk("reached_d_stb", {30'd0, ifc.Write, ifc.AoD}, 2'b01);
    #2 Reset = 1'b0;
    ifc.req[1] = 1'b0;
    #1;
    chk("abort_pins", {28'd0, ifc.ChipSelect, ifc.Write, ifc.AoD, ifc.bus_oe}, 4'b1110);
    chk("abort_busy_gnt", {27'd0, ifc.busy, ifc.gnt}, 0);
    chk("abort_rdata", {24'd0, ifc.rdata}, 0);
    repeat (3) @(negedge clk);
    #2 Reset = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {27'd0, ifc.busy, ifc.done}, 0);

    // Normal read after reset.
    rd_val = 8'hC3;
    sb.push_back(mk(0, 1'b0, 8'h30, 8'h00, 8'hC3, -1));
    do_req(0, 1'b0, 8'h30, 8'h00, 1);
    repeat (10) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
